// File: rtl/register_set_param.sv
// Parameterised register file behind a four-phase req/ack handshake.
// Supports plain, bit-set and bit-clear writes, per-register read-only masking and range errors.
module register_set_param #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_REGS = 64,
  parameter int unsigned ADDR_W = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   req,
  input  logic                         wnr,
  input  logic [ADDR_W-1:0]            address,
  input  logic [DATA_W-1:0]            data_in,
  output logic [DATA_W-1:0]            data_out,
  output logic                         ack,
  output logic                         err,
  output logic [NUM_REGS*DATA_W-1:0]   mem_data_out
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CMP_W = (ADDR_W > 32) ? ADDR_W : 32;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT_REL} state_t;

  state_t              state, state_d;
  logic [1:0]          req_q;
  logic                wnr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic                latch_en;
  logic                wr_en;
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   cur_val;
  logic [DATA_W-1:0]   op_val;
  logic [DATA_W-1:0]   data_out_d;
  logic                ack_d;
  logic                err_d;

  // Full address takes part in the range check, so aliasing upper bits cannot hit a register.
  assign in_range = CMP_W'(addr_q) < CMP_W'(NUM_REGS);
  assign idx      = addr_q[IDX_W-1:0];

  // Next-state, operation result and output values.
  always_comb begin
    state_d    = state;
    latch_en   = 1'b0;
    wr_en      = 1'b0;
    ack_d      = ack;
    err_d      = err;
    data_out_d = data_out;
    cur_val    = in_range ? regs[idx] : '0;
    case (req_q)
      2'b11:   op_val = cur_val | data_q;
      2'b10:   op_val = cur_val & ~data_q;
      default: op_val = data_q;
    endcase

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          latch_en = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        ack_d   = 1'b1;
        state_d = WAIT_REL;
        if (!in_range) begin
          err_d      = 1'b1;
          data_out_d = '0;
        end else if (wnr_q && RO_MASK[idx]) begin
          err_d      = 1'b1;
          data_out_d = cur_val;
        end else if (wnr_q) begin
          wr_en      = 1'b1;
          err_d      = 1'b0;
          data_out_d = op_val;
        end else begin
          err_d      = 1'b0;
          data_out_d = cur_val;
        end
      end
      WAIT_REL: begin
        if (req == 2'b00) begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request capture, outputs and register storage; reset overrides any pending write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ack      <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
      req_q    <= 2'b00;
      wnr_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL[i*DATA_W +: DATA_W];
      end
    end else begin
      state    <= state_d;
      ack      <= ack_d;
      err      <= err_d;
      data_out <= data_out_d;
      if (latch_en) begin
        req_q  <= req;
        wnr_q  <= wnr;
        addr_q <= address;
        data_q <= data_in;
      end
      if (wr_en) begin
        regs[idx] <= op_val;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign mem_data_out[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule
